// File: rtl/exe_pipe.sv
// rtl/exe_pipe.sv - pipelined execute unit: register file, 8-op ALU, result stage, writeback, forwarding
//
// Purpose: takes one decoded instruction per cycle, reads two operands from a
// REG_N x DATA_W register file (with single-level forwarding from the result
// stage), computes one of eight ALU operations with {V,C,N,Z} flags, and holds
// the result in a one-stage output register. The held result is written back to
// the register file on the next unstalled edge. A separate load port writes the
// register file directly on any non-reset edge.
//
// Ports:
//   i_clk, i_rst              clock, synchronous active-high reset
//   i_valid, i_oper           instruction present, opcode
//   i_reg0, i_reg1, i_reg2    source A, source B, destination
//   i_imm, i_data             operand B select (1 = immediate), signed immediate
//   i_stall                   freeze the result stage and writeback
//   i_ld_en, i_ld_reg, i_ld_data  external register load
//   o_valid, o_data, o_flag   registered result, valid flag, {V,C,N,Z}
module exe_pipe #(
  parameter int DATA_W = 6,
  parameter int REG_N  = 16,
  parameter int SAT    = 0,
  localparam int REG_AW = $clog2(REG_N)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  input  logic [2:0]        i_oper,
  input  logic [REG_AW-1:0] i_reg0,
  input  logic [REG_AW-1:0] i_reg1,
  input  logic [REG_AW-1:0] i_reg2,
  input  logic              i_imm,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_stall,
  input  logic              i_ld_en,
  input  logic [REG_AW-1:0] i_ld_reg,
  input  logic [DATA_W-1:0] i_ld_data,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic [3:0]        o_flag
);

  localparam int MSB  = DATA_W - 1;
  localparam int SH_W = $clog2(DATA_W) + 1;
  localparam logic [SH_W-1:0]   AMT_LIM = SH_W'(DATA_W);
  localparam logic [DATA_W-1:0] SMAX    = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SMIN    = {1'b1, {(DATA_W-1){1'b0}}};

  logic [DATA_W-1:0] r_regs [REG_N];
  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic [3:0]        r_flag;
  logic [REG_AW-1:0] r_dest;

  logic [DATA_W-1:0] w_a;
  logic [DATA_W-1:0] w_b;
  logic [SH_W-1:0]   w_amt;
  logic [DATA_W:0]   w_sum;
  logic [DATA_W:0]   w_dif;
  logic [DATA_W:0]   w_shl;
  logic signed [DATA_W:0] w_sar;
  logic [DATA_W-1:0] w_res;
  logic              w_c;
  logic              w_v;

  // Single forwarding level: the stage register is the only result not yet in the file.
  assign w_a = (r_valid && (r_dest == i_reg0)) ? r_data : r_regs[i_reg0];
  assign w_b = i_imm ? i_data :
               ((r_valid && (r_dest == i_reg1)) ? r_data : r_regs[i_reg1]);
  assign w_amt = w_b[SH_W-1:0];

  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    // One extra bit catches the carry / borrow out of the MSB.
    w_sum = {1'b0, w_a} + {1'b0, w_b};
    w_dif = {1'b0, w_a} - {1'b0, w_b};
    // SHL: bit DATA_W holds the last bit shifted out.
    w_shl = {1'b0, w_a} << w_amt;
    // SAR: a guard bit below the LSB holds the last bit shifted out.
    w_sar = $signed({w_a, 1'b0}) >>> w_amt;
    case (i_oper)
      3'd0: begin
        w_res = w_sum[MSB:0];
        w_c   = w_sum[DATA_W];
        w_v   = (w_a[MSB] == w_b[MSB]) && (w_res[MSB] != w_a[MSB]);
      end
      3'd1: begin
        w_res = w_dif[MSB:0];
        w_c   = w_dif[DATA_W];
        w_v   = (w_a[MSB] != w_b[MSB]) && (w_res[MSB] != w_a[MSB]);
      end
      3'd2: w_res = w_a & w_b;
      3'd3: w_res = w_a | w_b;
      3'd4: w_res = w_a ^ w_b;
      3'd5: begin
        if (w_amt < AMT_LIM) begin
          w_res = w_shl[MSB:0];
          w_c   = w_shl[DATA_W];
        end
      end
      3'd6: begin
        if (w_amt < AMT_LIM) begin
          w_res = w_sar[DATA_W:1];
          w_c   = w_sar[0];
        end else begin
          w_res = {DATA_W{w_a[MSB]}};
        end
      end
      default: w_res = w_b;
    endcase
    // Overflow direction always follows the sign of A for both ADD and SUB.
    if ((SAT != 0) && w_v) begin
      w_res = w_a[MSB] ? SMIN : SMAX;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_flag  <= '0;
      r_dest  <= '0;
      for (int i = 0; i < REG_N; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      if (i_ld_en) begin
        r_regs[i_ld_reg] <= i_ld_data;
      end
      if (!i_stall) begin
        // Issued after the load so writeback wins a same-register collision.
        if (r_valid) begin
          r_regs[r_dest] <= r_data;
        end
        r_valid <= i_valid;
        if (i_valid) begin
          r_data <= w_res;
          r_flag <= {w_v, w_c, w_res[MSB], (w_res == '0)};
          r_dest <= i_reg2;
        end
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_flag  = r_flag;

endmodule

// File: tb/tb_exe_pipe.sv
// tb/tb_exe_pipe.sv - self-checking bench for exe_pipe (wrapping and saturating instances)
module tb_exe_pipe;

  localparam int W    = 6;
  localparam int MASK = (1 << W) - 1;
  localparam int MAXV = (1 << (W - 1)) - 1;
  localparam int MINV = -(1 << (W - 1));
  localparam int AMTM = (1 << ($clog2(W) + 1)) - 1;

  logic       clk = 1'b0;
  logic       rst, valid, imm, stall, ld_en;
  logic [2:0] oper;
  logic [3:0] reg0, reg1, reg2, ld_reg;
  logic [5:0] data, ld_data;
  logic [1:0] o_valid;
  logic [5:0] o_data [2];
  logic [3:0] o_flag [2];

  int checks = 0;
  int failures = 0;

  int         m_reg  [2][16];
  bit         m_val  [2];
  int         m_data [2];
  logic [3:0] m_flag [2];
  int         m_dest [2];

  always #5 clk = ~clk;

  exe_pipe #(.DATA_W(6), .REG_N(16), .SAT(0)) u_dut_wrap (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_oper(oper),
    .i_reg0(reg0), .i_reg1(reg1), .i_reg2(reg2), .i_imm(imm), .i_data(data),
    .i_stall(stall), .i_ld_en(ld_en), .i_ld_reg(ld_reg), .i_ld_data(ld_data),
    .o_valid(o_valid[0]), .o_data(o_data[0]), .o_flag(o_flag[0])
  );

  exe_pipe #(.DATA_W(6), .REG_N(16), .SAT(1)) u_dut_sat (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_oper(oper),
    .i_reg0(reg0), .i_reg1(reg1), .i_reg2(reg2), .i_imm(imm), .i_data(data),
    .i_stall(stall), .i_ld_en(ld_en), .i_ld_reg(ld_reg), .i_ld_data(ld_data),
    .o_valid(o_valid[1]), .o_data(o_data[1]), .o_flag(o_flag[1])
  );

  function automatic int wrap(input int x);
    int y;
    y = x & MASK;
    return (y > MAXV) ? y - (1 << W) : y;
  endfunction

  // Reference ALU on plain signed integers.
  function automatic void ref_alu(input int op, input int a, input int b, input bit sat,
                                  output int r, output logic [3:0] f);
    int ua, ub, amt, t;
    bit c, v;
    ua = a & MASK;
    ub = b & MASK;
    amt = ub & AMTM;
    c = 0;
    v = 0;
    r = 0;
    case (op)
      0, 1: begin
        t = (op == 0) ? a + b : a - b;
        c = (op == 0) ? ((ua + ub) > MASK) : (ua < ub);
        v = (t > MAXV) || (t < MINV);
        r = (sat && v) ? ((t > MAXV) ? MAXV : MINV) : wrap(t);
      end
      2: r = wrap(ua & ub);
      3: r = wrap(ua | ub);
      4: r = wrap(ua ^ ub);
      5: begin
        if (amt == 0) r = a;
        else if (amt >= W) r = 0;
        else begin
          t = ua * (1 << amt);
          c = ((t >> W) & 1) == 1;
          r = wrap(t);
        end
      end
      6: begin
        if (amt == 0) r = a;
        else if (amt >= W) r = (a < 0) ? -1 : 0;
        else begin
          r = a >>> amt;
          c = ((ua >> (amt - 1)) & 1) == 1;
        end
      end
      default: r = b;
    endcase
    f = {v, c, (r < 0), (r == 0)};
  endfunction

  task automatic model_step();
    int a, b, r;
    logic [3:0] f;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        for (int i = 0; i < 16; i++) m_reg[k][i] = 0;
        m_val[k] = 0; m_data[k] = 0; m_flag[k] = 4'h0; m_dest[k] = 0;
      end else begin
        a = (m_val[k] && m_dest[k] == int'(reg0)) ? m_data[k] : m_reg[k][reg0];
        if (imm) b = wrap(int'(data));
        else b = (m_val[k] && m_dest[k] == int'(reg1)) ? m_data[k] : m_reg[k][reg1];
        ref_alu(int'(oper), a, b, (k == 1), r, f);
        if (ld_en) m_reg[k][ld_reg] = wrap(int'(ld_data));
        if (!stall && m_val[k]) m_reg[k][m_dest[k]] = m_data[k];
        if (!stall) begin
          if (valid) begin
            m_data[k] = r; m_flag[k] = f; m_dest[k] = int'(reg2);
          end
          m_val[k] = valid;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    int d;
    model_step();
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      d = m_data[k];
      chk(k ? "sat_valid" : "wrap_valid", {31'd0, o_valid[k]}, {31'd0, m_val[k]});
      chk(k ? "sat_data" : "wrap_data", {26'd0, o_data[k]}, {26'd0, d[5:0]});
      chk(k ? "sat_flag" : "wrap_flag", {28'd0, o_flag[k]}, {28'd0, m_flag[k]});
    end
  endtask

  task automatic clr();
    rst = 0; valid = 0; imm = 0; stall = 0; ld_en = 0;
    oper = 3'd0; reg0 = 4'd0; reg1 = 4'd0; reg2 = 4'd0;
    data = 6'd0; ld_reg = 4'd0; ld_data = 6'd0;
  endtask

  task automatic issue(input int op, input int r0, input int r1, input int r2,
                       input bit im, input int d);
    clr();
    valid = 1; oper = op[2:0]; reg0 = r0[3:0]; reg1 = r1[3:0]; reg2 = r2[3:0];
    imm = im; data = d[5:0];
  endtask

  task automatic load(input int r, input int d);
    clr();
    ld_en = 1; ld_reg = r[3:0]; ld_data = d[5:0];
  endtask

  initial begin
    clr();
    rst = 1;
    tick(); tick();
    chk("reset_valid", {30'd0, o_valid}, 32'd0);
    chk("reset_data", {26'd0, o_data[0]}, 32'd0);
    chk("reset_flag", {28'd0, o_flag[1]}, 32'd0);

    // Signed overflow: wrap vs saturate.
    load(1, 31); tick();
    issue(0, 1, 0, 2, 1, 1); tick();
    chk("add_wrap_data", {26'd0, o_data[0]}, 32'b100000);
    chk("add_wrap_flag", {28'd0, o_flag[0]}, 32'b1010);
    chk("add_sat_data", {26'd0, o_data[1]}, 32'b011111);
    chk("add_sat_flag", {28'd0, o_flag[1]}, 32'b1000);
    clr(); tick();
    issue(7, 0, 2, 9, 0, 0); tick();
    chk("r2_after_wb", {26'd0, o_data[0]}, 32'b100000);
    load(1, -32); tick();
    issue(1, 1, 0, 10, 1, 1); tick();
    chk("sub_sat_data", {26'd0, o_data[1]}, 32'b100000);
    chk("sub_sat_flag", {28'd0, o_flag[1]}, 32'b1010);

    // Forwarding at distance 1, register file at distance 2.
    issue(7, 0, 0, 3, 1, 5); tick();
    issue(0, 3, 3, 4, 0, 0); tick();
    chk("fwd_add", {26'd0, o_data[0]}, 32'd10);
    clr(); tick();
    issue(7, 0, 4, 11, 0, 0); tick();
    chk("dist2_read", {26'd0, o_data[1]}, 32'd10);

    // Stall holds the stage and drops the presented instruction.
    issue(0, 0, 0, 5, 1, 7); tick();
    for (int i = 0; i < 3; i++) begin
      issue(7, 0, 0, 6, 1, 20); stall = 1; tick();
      chk("stall_hold", {26'd0, o_data[0]}, 32'd7);
    end
    clr(); tick();
    issue(7, 0, 5, 12, 0, 0); tick();
    chk("r5_written", {26'd0, o_data[0]}, 32'd7);
    issue(7, 0, 6, 12, 0, 0); tick();
    chk("r6_untouched", {26'd0, o_data[0]}, 32'd0);

    // Load/writeback collisions.
    issue(7, 0, 0, 7, 1, 9); tick();
    load(7, 2); tick();
    issue(7, 0, 7, 13, 0, 0); tick();
    chk("collide_wb_wins", {26'd0, o_data[0]}, 32'd9);
    issue(7, 0, 0, 7, 1, 3); tick();
    load(8, 2); tick();
    issue(7, 0, 7, 13, 0, 0); tick();
    chk("both_r7", {26'd0, o_data[0]}, 32'd3);
    issue(7, 0, 8, 13, 0, 0); tick();
    chk("both_r8", {26'd0, o_data[0]}, 32'd2);

    // Shifts and shift boundaries.
    load(1, -16); tick();
    issue(6, 1, 0, 14, 1, 2); tick();
    chk("sar2_data", {26'd0, o_data[0]}, 32'b111100);
    chk("sar2_flag", {28'd0, o_flag[0]}, 32'b0010);
    issue(5, 1, 0, 15, 1, 1); tick();
    chk("shl1_data", {26'd0, o_data[0]}, 32'b100000);
    chk("shl1_flag", {28'd0, o_flag[0]}, 32'b0110);
    issue(5, 1, 0, 15, 1, 6); tick();
    chk("shl6_flag", {28'd0, o_flag[0]}, 32'b0001);
    issue(6, 1, 0, 15, 1, 7); tick();
    chk("sar7_data", {26'd0, o_data[0]}, 32'b111111);
    issue(5, 1, 0, 15, 1, 0); tick();
    chk("shl0_flag", {28'd0, o_flag[0]}, 32'b0010);

    // Reset during stall discards the pending result.
    issue(0, 0, 0, 5, 1, 3); tick();
    clr(); rst = 1; stall = 1; tick();
    chk("rst_stall_valid", {30'd0, o_valid}, 32'd0);
    clr(); tick();
    issue(7, 0, 5, 12, 0, 0); tick();
    chk("rst_no_wb", {26'd0, o_data[0]}, 32'd0);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      clr();
      rst     = ($urandom_range(0, 99) == 0);
      valid   = ($urandom_range(0, 9) < 8);
      oper    = 3'($urandom_range(0, 7));
      reg0    = 4'($urandom_range(0, 15));
      reg1    = 4'($urandom_range(0, 15));
      reg2    = 4'($urandom_range(0, 15));
      imm     = $urandom_range(0, 1) == 1;
      data    = 6'($urandom_range(0, 63));
      stall   = ($urandom_range(0, 4) == 0);
      ld_en   = ($urandom_range(0, 2) == 0);
      ld_reg  = 4'($urandom_range(0, 15));
      ld_data = 6'($urandom_range(0, 63));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
